// File: rtl/disp_channel_sequencer.sv
// Channel-select / latch-enable sequencer for the 8-channel display mux.
// Define DISP_SEQ_BLANK_EN to blank the display between channel switch and load.
module disp_channel_sequencer #(
  parameter int unsigned DWELL_CYC = 32'd50_000_000,
  parameter int unsigned DWELL_W   = 32'd26,
  parameter int unsigned BLANK_CYC = 32'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic [2:0] sw_sel,
  input  logic       step,
  input  logic [7:0] ch_mask,
  output logic [2:0] Test,
  output logic       EN,
  output logic       chg,
  output logic       blank
);

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_STEP   = 2'b01;
  localparam logic [1:0] MODE_AUTO   = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYC - 32'd1);
  localparam logic [DWELL_W-1:0] CNT_ONE    = DWELL_W'(32'd1);

  if ((DWELL_CYC < 32'd1) || (BLANK_CYC < 32'd1) ||
      ((64'd1 << DWELL_W) <= 64'(DWELL_CYC))) begin : g_param_check
    $error("disp_channel_sequencer: DWELL_CYC/DWELL_W/BLANK_CYC out of range");
  end

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_DWELL  = 2'd1,
    S_SWITCH = 2'd2
`ifdef DISP_SEQ_BLANK_EN
    , S_BLANK = 2'd3
`endif
  } state_t;

  // First eligible channel above cur (wrapping); an empty mask means channel 0 only.
  function automatic logic [2:0] next_eligible(input logic [2:0] cur, input logic [7:0] mask);
    logic [7:0] m;
    logic [2:0] res;
    logic [2:0] c;
    m   = (mask == 8'h00) ? 8'h01 : mask;
    res = cur;
    for (int k = 7; k >= 1; k--) begin
      c = cur + k[2:0];
      if (m[c]) begin
        res = c;
      end
    end
    return res;
  endfunction

  state_t             state_q;
  logic [2:0]         test_q;
  logic [2:0]         target_q;
  logic [2:0]         sw_q;
  logic [1:0]         mode_q;
  logic               en_q;
  logic               chg_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [2:0]         next_ch;
`ifdef DISP_SEQ_BLANK_EN
  localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYC - 32'd1);
  logic [7:0]         bcnt_q;
  logic               blank_q;
`endif

  assign next_ch = next_eligible(test_q, ch_mask);

  // Sequencer FSM; every output is a register written here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_LOAD;
      test_q   <= 3'd0;
      target_q <= 3'd0;
      sw_q     <= 3'd0;
      mode_q   <= 2'b00;
      en_q     <= 1'b0;
      chg_q    <= 1'b0;
      cnt_q    <= '0;
`ifdef DISP_SEQ_BLANK_EN
      bcnt_q   <= 8'd0;
      blank_q  <= 1'b0;
`endif
    end else begin
      sw_q   <= sw_sel;
      mode_q <= mode;
      en_q   <= 1'b0;
      chg_q  <= 1'b0;
      case (state_q)
        S_LOAD: begin
          en_q    <= 1'b1;
          cnt_q   <= '0;
          state_q <= S_DWELL;
`ifdef DISP_SEQ_BLANK_EN
          blank_q <= 1'b0;
`endif
        end
        S_DWELL: begin
          // A mode change only restarts the dwell; the new mode acts from the next cycle.
          if (mode != mode_q) begin
            cnt_q <= '0;
          end else begin
            case (mode)
              MODE_AUTO: begin
                if (cnt_q == DWELL_LAST) begin
                  cnt_q <= '0;
                  if (next_ch != test_q) begin
                    target_q <= next_ch;
                    state_q  <= S_SWITCH;
                  end
                end else begin
                  cnt_q <= cnt_q + CNT_ONE;
                end
              end
              MODE_STEP: begin
                cnt_q <= '0;
                if (step && (next_ch != test_q)) begin
                  target_q <= next_ch;
                  state_q  <= S_SWITCH;
                end
              end
              MODE_DIRECT: begin
                cnt_q <= '0;
                if (sw_q != test_q) begin
                  target_q <= sw_q;
                  state_q  <= S_SWITCH;
                end
              end
              MODE_HOLD: begin
                cnt_q <= cnt_q;
              end
              default: begin
                cnt_q <= '0;
              end
            endcase
          end
        end
        S_SWITCH: begin
          test_q <= target_q;
          chg_q  <= 1'b1;
`ifdef DISP_SEQ_BLANK_EN
          blank_q <= 1'b1;
          bcnt_q  <= 8'd0;
          state_q <= S_BLANK;
`else
          state_q <= S_LOAD;
`endif
        end
`ifdef DISP_SEQ_BLANK_EN
        S_BLANK: begin
          if (bcnt_q == BLANK_LAST) begin
            state_q <= S_LOAD;
          end else begin
            bcnt_q <= bcnt_q + 8'd1;
          end
        end
`endif
        default: begin
          state_q <= S_LOAD;
        end
      endcase
    end
  end

  assign Test = test_q;
  assign EN   = en_q;
  assign chg  = chg_q;
`ifdef DISP_SEQ_BLANK_EN
  assign blank = blank_q;
`else
  assign blank = 1'b0;
`endif

endmodule
